// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer: four-digit BCD value {s_tens, s_ones, ds, cs} that
// counts down one LSB per prescaler tick, with start/pause toggling from a
// single level input and a terminal DONE state that only load or reset leave.
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic        MAX10_CLK1_50,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start_stop,
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        done_pulse
);

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DW     = 4;
  localparam int unsigned CW     = DIGITS * DW;
  localparam int unsigned PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_presc;
  logic          r_ss_prev;
  logic          r_ss_armed;
  logic          r_running;
  logic          r_done;
  logic          r_done_pulse;

  logic          w_event;
  logic          w_tick;
  logic          w_last_tick;
  logic          w_running_d;
  logic          w_done_d;
  logic          w_done_pulse_d;
  logic [CW-1:0] w_count_dec;
  logic [CW-1:0] w_preset_clamped;

  // Digit-wise BCD decrement: a zero digit becomes 9 and passes the borrow up.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] res;
    logic [DW-1:0] d;
    logic          borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = v[i*DW +: DW];
      if (borrow) begin
        if (d == DW'(0)) begin
          d = DW'(9);
        end else begin
          d      = d - DW'(1);
          borrow = 1'b0;
        end
      end
      res[i*DW +: DW] = d;
    end
    return res;
  endfunction

  // Clamp each preset digit into the legal BCD range 0..9.
  function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
    logic [CW-1:0] res;
    logic [DW-1:0] d;
    res = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = v[i*DW +: DW];
      if (d > DW'(9)) begin
        d = DW'(9);
      end
      res[i*DW +: DW] = d;
    end
    return res;
  endfunction

  assign w_count_dec      = bcd_dec(r_count);
  assign w_preset_clamped = bcd_clamp(preset);

  // Rising edge of start_stop; the armed flag blocks a level already high at reset release.
  assign w_event     = start_stop & ~r_ss_prev & r_ss_armed;
  assign w_tick      = (r_state == S_RUN) && (r_presc == PRESC_MAX);
  assign w_last_tick = w_tick && (r_count == CNT_ONE);

  // start_stop history for edge detection.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_ss_prev  <= 1'b0;
      r_ss_armed <= 1'b0;
    end else begin
      r_ss_prev  <= start_stop;
      r_ss_armed <= r_ss_armed | ~start_stop;
    end
  end

  // State register.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; load overrides any same-cycle toggle event.
  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            w_state_nxt = (r_count == CNT_ZERO) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_last_tick) begin
            w_state_nxt = S_DONE;
          end else if (w_event) begin
            w_state_nxt = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (w_event) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the flags register in step with it.
  always_comb begin
    w_running_d    = 1'b0;
    w_done_d       = 1'b0;
    w_done_pulse_d = 1'b0;
    if (w_state_nxt == S_RUN) begin
      w_running_d = 1'b1;
    end
    if (w_state_nxt == S_DONE) begin
      w_done_d       = 1'b1;
      w_done_pulse_d = (r_state != S_DONE);
    end
  end

  // Registered status outputs.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_running    <= w_running_d;
      r_done       <= w_done_d;
      r_done_pulse <= w_done_pulse_d;
    end
  end

  // Prescaler and BCD count: run in RUN, hold in PAUSE, cleared otherwise.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_count <= CNT_ZERO;
      r_presc <= PW'(0);
    end else if (load) begin
      r_count <= w_preset_clamped;
      r_presc <= PW'(0);
    end else if (w_tick) begin
      r_presc <= PW'(0);
      if (r_count != CNT_ZERO) begin
        r_count <= w_count_dec;
      end
    end else if (r_state == S_RUN) begin
      r_presc <= r_presc + PW'(1);
    end else if (r_state != S_PAUSE) begin
      r_presc <= PW'(0);
    end
  end

  assign count      = r_count;
  assign running    = r_running;
  assign done       = r_done;
  assign done_pulse = r_done_pulse;

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, meaning MAX10_CLK1_50 cycles per count tick (100 Hz at 50 MHz); legal range 2 or more.
REQ-002 SHALL have port MAX10_CLK1_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port load, input, 1 bit: when high, copy preset into count.
REQ-005 SHALL have port preset, input, 16 bits: BCD start value {s_tens, s_ones, ds, cs}, 4 bits each.
REQ-006 SHALL have port start_stop, input, 1 bit: level input; each rising edge is one toggle event.
REQ-007 SHALL have port count, output, 16 bits: current BCD value, same digit order as preset.
REQ-008 SHALL have port running, output, 1 bit: high while in RUN.
REQ-009 SHALL have port done, output, 1 bit: high while in DONE.
REQ-010 SHALL have port done_pulse, output, 1 bit: one-cycle strobe on entry to DONE.

Function
REQ-011 SHALL implement states IDLE, RUN, PAUSE and DONE; running and done SHALL be registered Moore outputs decoded from state.
REQ-012 SHALL detect a start_stop event as start_stop=1 with the registered previous sample=0; an input held high SHALL produce exactly one event.
REQ-013 On load=1 in any state, on that edge: count gets preset with each digit above 9 clamped to 9; state goes to IDLE; prescaler clears to 0.
REQ-014 load SHALL take priority over a same-cycle start_stop event; that event is discarded.
REQ-015 State transitions on an event:
  - IDLE with count not 0x0000: go to RUN.
  - IDLE with count 0x0000: go to DONE.
  - RUN: go to PAUSE.
  - PAUSE: go to RUN.
  - DONE: ignore the event; leaving DONE requires load or reset.
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, hold its value in PAUSE, and be 0 in IDLE and DONE.
REQ-017 When the prescaler is at TICK_DIV-1 in RUN, on that edge the prescaler SHALL wrap to 0 and count SHALL decrement by one BCD LSB.
REQ-018 BCD decrement SHALL work digit-wise: a digit at 0 becomes 9 and borrows from the next digit up; only in-range values 0-9 SHALL appear on any digit.
REQ-019 A tick with count=0x0001 SHALL set count to 0x0000 and the state to DONE on the same edge; done SHALL be high from the following cycle.
REQ-020 count SHALL never decrement below 0x0000, i.e. no wrap to 0x9999.
REQ-021 done_pulse SHALL be high for exactly the first cycle in which done is high, including DONE entered from IDLE.
REQ-022 A start_stop event and a tick on the same RUN edge: the decrement SHALL be applied and the state SHALL go to PAUSE.
REQ-023 count SHALL change only on load, tick or reset.

Reset
REQ-024 While reset=1, asynchronously: count=0x0000, state=IDLE, prescaler=0, previous start_stop sample=0, running=0, done=0, done_pulse=0.
REQ-025 Reset asserted mid-RUN SHALL abort the countdown immediately, without waiting for a clock edge.
REQ-026 After reset deassertion, start_stop already high SHALL NOT count as an event until it falls and rises again.

Verification (TICK_DIV=4)
REQ-027 Reset pulse -> count=0x0000, running=0, done=0, done_pulse=0.
REQ-028 Load 0x0102, then a start_stop rising edge -> count follows 0x0101, 0x0100, 0x0099, with one step every 4 cycles.
REQ-029 Load 0x0001, then start -> after 4 cycles count=0x0000 and running=0; done=1 from the next cycle; done_pulse high for 1 cycle; further events keep DONE.
REQ-030 Start from 0x0050, toggle to PAUSE 2 cycles after a tick, wait 20 cycles, toggle to RUN -> count is unchanged during the pause; next decrement arrives 2 cycles after resume.
REQ-031 Load 0xFA3C -> count=0x9939. Load with count=0x0000 then start -> done=1 with no decrement.
REQ-032 Assert reset mid-RUN between edges -> count=0x0000 and running=0 immediately. start_stop held high across reset release -> stays IDLE.
